memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
Pipeline stage directly downstream of the execute stage. Takes the ALU result as a data-memory address (loads/stores) or as a pass-through result, runs a req/ack handshake with data memory, and presents a registered result to the writeback stage. Stalls upstream while a memory access is outstanding; aborts on misalignment or timeout.

Parameters:
TIMEOUT, 255, max cycles dmem_req stays high without dmem_ack before abort (1..65535)
DEST_WIDTH, 5, register-file destination index width

Ports:
CLOCK_50  input  1  system clock, all state on rising edge
resetn  input  1  asynchronous active-low reset
valid_in  input  1  execute result valid this cycle
alu_out  input  32  ALU result; memory byte address when mem_read/mem_write
store_data  input  32  data for stores (execute's alu_B operand)
mem_read  input  1  instruction is a load
mem_write  input  1  instruction is a store
reg_write  input  1  instruction writes a register
dest_reg  input  DEST_WIDTH  destination register index
stall  output  1  upstream must hold inputs stable (combinational)
dmem_req  output  1  memory request, held until ack
dmem_we  output  1  1 = store, 0 = load
dmem_addr  output  32  word-aligned byte address
dmem_wdata  output  32  store data
dmem_rdata  input  32  load data, valid with dmem_ack
dmem_ack  input  1  memory completion, sampled only while dmem_req=1
wb_valid  output  1  one-cycle pulse: result for writeback
wb_data  output  32  load data or pass-through ALU result
wb_dest  output  DEST_WIDTH  destination index
wb_reg_write  output  1  writeback enable (forced 0 on error)
mem_error  output  1  one-cycle pulse with wb_valid: misaligned or timed-out access

Behaviour:
- Reset (resetn=0, async): state IDLE; dmem_req, dmem_we, wb_valid, wb_reg_write, mem_error = 0; dmem_addr, dmem_wdata, wb_data, wb_dest = 0; timeout counter = 0. Reset mid-access drops dmem_req immediately; no writeback pulse follows.
- States: IDLE, ACCESS.
- stall = (state==ACCESS) | (valid_in & (mem_read|mem_write) & state==IDLE & aligned).
- mem_read and mem_write both set: treated as store.
- IDLE, valid_in=1, no mem op: next edge wb_valid=1, wb_data=alu_out, wb_dest=dest_reg, wb_reg_write=reg_write. Latency 1 cycle, back-to-back each cycle.
- IDLE, mem op, alu_out[1:0]!=0: no request; next edge wb_valid=1, mem_error=1, wb_reg_write=0, wb_data=alu_out; state stays IDLE; stall not asserted.
- IDLE, mem op, aligned: next edge dmem_req=1, dmem_we=mem_write, dmem_addr=alu_out, dmem_wdata=store_data, dest/reg_write latched, counter=0, go ACCESS.
- ACCESS: dmem_req/we/addr/wdata held stable. Each edge with dmem_ack=1: dmem_req=0, wb_valid=1 next cycle; load -> wb_data=dmem_rdata, wb_reg_write=latched reg_write; store -> wb_data=dmem_addr, wb_reg_write=0; back to IDLE. Ack allowed in first req cycle (min memory latency 2 edges from acceptance to wb_valid).
- No ack: counter increments each ACCESS cycle; at counter==TIMEOUT-1 with no ack: dmem_req=0, wb_valid=1, mem_error=1, wb_reg_write=0, IDLE. Ack in same cycle as timeout wins (normal completion).
- Counter 16 bits, saturating never reached (bounded by TIMEOUT).
- wb_valid, mem_error single-cycle pulses; wb_data/wb_dest hold last value when wb_valid=0.
- dmem_ack while dmem_req=0 ignored.
- New instruction accepted in IDLE the cycle after return from ACCESS (stall falls combinationally on IDLE entry).

Test Plan:
- Pass-through: valid_in, alu_out=0x0000_1234, reg_write=1, dest_reg=7 -> next cycle wb_valid=1, wb_data=0x1234, wb_dest=7, no dmem_req, stall=0.
- Load, ack after 3 cycles, dmem_rdata=0xDEAD_BEEF, addr 0x100 -> dmem_req high 3 cycles, dmem_addr=0x100, dmem_we=0, stall high throughout, wb_data=0xDEADBEEF, wb_reg_write=1 one cycle after ack.
- Store addr 0x40 data 0xA5A5_A5A5, ack in first req cycle -> dmem_we=1, dmem_wdata=0xA5A5A5A5, wb_valid pulse with wb_reg_write=0, mem_error=0.
- Misaligned load addr 0x102 -> no dmem_req; next cycle wb_valid=1, mem_error=1, wb_reg_write=0.
- TIMEOUT=4, no ack -> dmem_req drops after 4 cycles, mem_error=1, wb_reg_write=0; stray ack afterwards ignored.
- resetn low during ACCESS -> dmem_req=0 immediately, no wb_valid after release, next pass-through completes normally.

Source files
------------

// File: rtl/memory_stage.sv
// Memory stage: forwards ALU results or runs a req/ack data-memory access,
// presenting a registered one-cycle writeback pulse; aborts on misalignment or timeout.
module memory_stage #(
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned DEST_WIDTH = 5
) (
  input  logic                  CLOCK_50,
  input  logic                  resetn,
  input  logic                  valid_in,
  input  logic [31:0]           alu_out,
  input  logic [31:0]           store_data,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  reg_write,
  input  logic [DEST_WIDTH-1:0] dest_reg,
  output logic                  stall,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [31:0]           dmem_addr,
  output logic [31:0]           dmem_wdata,
  input  logic [31:0]           dmem_rdata,
  input  logic                  dmem_ack,
  output logic                  wb_valid,
  output logic [31:0]           wb_data,
  output logic [DEST_WIDTH-1:0] wb_dest,
  output logic                  wb_reg_write,
  output logic                  mem_error
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t                state, state_d;
  logic [15:0]           cnt, cnt_d;
  logic                  rw_lat, rw_lat_d;
  logic [DEST_WIDTH-1:0] dest_lat, dest_lat_d;

  logic                  dmem_req_d, dmem_we_d;
  logic [31:0]           dmem_addr_d, dmem_wdata_d, wb_data_d;
  logic                  wb_valid_d, wb_reg_write_d, mem_error_d;
  logic [DEST_WIDTH-1:0] wb_dest_d;

  logic mem_op, aligned;

  assign mem_op  = mem_read | mem_write;
  assign aligned = (alu_out[1:0] == 2'b00);
  assign stall   = (state == ACCESS) | (valid_in & mem_op & aligned & (state == IDLE));

  always_comb begin
    state_d        = state;
    cnt_d          = cnt;
    rw_lat_d       = rw_lat;
    dest_lat_d     = dest_lat;
    dmem_req_d     = dmem_req;
    dmem_we_d      = dmem_we;
    dmem_addr_d    = dmem_addr;
    dmem_wdata_d   = dmem_wdata;
    wb_data_d      = wb_data;
    wb_dest_d      = wb_dest;
    wb_reg_write_d = wb_reg_write;
    wb_valid_d     = 1'b0;
    mem_error_d    = 1'b0;

    unique case (state)
      IDLE: begin
        if (valid_in) begin
          if (!mem_op) begin
            wb_valid_d     = 1'b1;
            wb_data_d      = alu_out;
            wb_dest_d      = dest_reg;
            wb_reg_write_d = reg_write;
          end else if (!aligned) begin
            wb_valid_d     = 1'b1;
            mem_error_d    = 1'b1;
            wb_data_d      = alu_out;
            wb_dest_d      = dest_reg;
            wb_reg_write_d = 1'b0;
          end else begin
            // a simultaneous read+write is issued as a store
            dmem_req_d   = 1'b1;
            dmem_we_d    = mem_write;
            dmem_addr_d  = alu_out;
            dmem_wdata_d = store_data;
            dest_lat_d   = dest_reg;
            rw_lat_d     = reg_write;
            cnt_d        = '0;
            state_d      = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          dmem_req_d     = 1'b0;
          wb_valid_d     = 1'b1;
          wb_dest_d      = dest_lat;
          wb_data_d      = dmem_we ? dmem_addr : dmem_rdata;
          wb_reg_write_d = dmem_we ? 1'b0 : rw_lat;
          state_d        = IDLE;
        end else if (cnt == CNT_LAST) begin
          dmem_req_d     = 1'b0;
          wb_valid_d     = 1'b1;
          mem_error_d    = 1'b1;
          wb_dest_d      = dest_lat;
          wb_data_d      = dmem_addr;
          wb_reg_write_d = 1'b0;
          state_d        = IDLE;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      cnt          <= '0;
      rw_lat       <= 1'b0;
      dest_lat     <= '0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      wb_dest      <= '0;
      wb_reg_write <= 1'b0;
      mem_error    <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      rw_lat       <= rw_lat_d;
      dest_lat     <= dest_lat_d;
      dmem_req     <= dmem_req_d;
      dmem_we      <= dmem_we_d;
      dmem_addr    <= dmem_addr_d;
      dmem_wdata   <= dmem_wdata_d;
      wb_valid     <= wb_valid_d;
      wb_data      <= wb_data_d;
      wb_dest      <= wb_dest_d;
      wb_reg_write <= wb_reg_write_d;
      mem_error    <= mem_error_d;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed cases then random instructions against a
// transaction-level model acting as both upstream and data memory.
module tb_memory_stage;

  localparam int unsigned TO = 4;
  localparam int unsigned DW = 5;

  logic          CLOCK_50 = 1'b0;
  logic          resetn;
  logic          valid_in;
  logic [31:0]   alu_out, store_data;
  logic          mem_read, mem_write, reg_write;
  logic [DW-1:0] dest_reg;
  logic          stall, dmem_req, dmem_we;
  logic [31:0]   dmem_addr, dmem_wdata, dmem_rdata;
  logic          dmem_ack;
  logic          wb_valid;
  logic [31:0]   wb_data;
  logic [DW-1:0] wb_dest;
  logic          wb_reg_write, mem_error;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_data;
  bit          data_known;

  memory_stage #(.TIMEOUT(TO), .DEST_WIDTH(DW)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .valid_in(valid_in), .alu_out(alu_out),
    .store_data(store_data), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .dest_reg(dest_reg), .stall(stall), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .wb_valid(wb_valid),
    .wb_data(wb_data), .wb_dest(wb_dest), .wb_reg_write(wb_reg_write),
    .mem_error(mem_error)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] sd, input logic rw, input logic [DW-1:0] dst);
    valid_in = 1'b1; mem_read = rd; mem_write = wr; alu_out = addr;
    store_data = sd; reg_write = rw; dest_reg = dst;
  endtask

  // One instruction. ack_dly = req cycles seen before ack (>= TO means never acked).
  task automatic run_instr(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] sd, input logic rw, input logic [DW-1:0] dst,
                           input int ack_dly, input bit stray);
    bit is_mem, is_al, is_st, timed_out;
    int req_cycles;
    logic [31:0] rdat;
    is_mem = rd | wr;
    is_al  = (addr % 4) == 0;
    is_st  = wr;
    drive(rd, wr, addr, sd, rw, dst);
    dmem_ack = 1'b0;
    #1;
    chk("stall_issue", stall, is_mem && is_al);
    chk("req_idle", dmem_req, 0);
    if (!is_mem || !is_al) begin
      @(negedge CLOCK_50); #1;
      chk("wb_valid", wb_valid, 1);
      chk("wb_data", wb_data, addr);
      chk("mem_error", mem_error, is_mem);
      chk("wb_reg_write", wb_reg_write, is_mem ? 1'b0 : rw);
      if (!is_mem) chk("wb_dest", wb_dest, dst);
      chk("req_none", dmem_req, 0);
      exp_data = addr; data_known = 1;
      return;
    end
    @(negedge CLOCK_50);
    valid_in = 1'b0;
    timed_out  = ack_dly >= int'(TO);
    req_cycles = timed_out ? int'(TO) : ack_dly + 1;
    rdat = $urandom();
    for (int k = 0; k < req_cycles; k++) begin
      #1;
      chk("req_held", dmem_req, 1);
      chk("stall_access", stall, 1);
      chk("dmem_addr", dmem_addr, addr);
      chk("dmem_we", dmem_we, is_st);
      if (is_st) chk("dmem_wdata", dmem_wdata, sd);
      chk("wb_quiet", wb_valid, 0);
      dmem_ack   = (k == ack_dly);
      dmem_rdata = (k == ack_dly) ? rdat : $urandom();
      @(negedge CLOCK_50);
    end
    dmem_ack = 1'b0;
    #1;
    chk("req_done", dmem_req, 0);
    chk("stall_done", stall, 0);
    chk("wb_valid_mem", wb_valid, 1);
    chk("mem_error_mem", mem_error, timed_out);
    chk("wb_reg_write_mem", wb_reg_write, (timed_out || is_st) ? 1'b0 : rw);
    if (!timed_out) begin
      chk("wb_data_mem", wb_data, is_st ? addr : rdat);
      chk("wb_dest_mem", wb_dest, dst);
      exp_data = is_st ? addr : rdat; data_known = 1;
    end else data_known = 0;
    if (stray) begin
      dmem_ack = 1'b1; dmem_rdata = $urandom();
      @(negedge CLOCK_50); #1;
      chk("stray_wb", wb_valid, 0);
      chk("stray_req", dmem_req, 0);
      dmem_ack = 1'b0;
    end
  endtask

  task automatic idle_cycle();
    valid_in = 1'b0;
    @(negedge CLOCK_50); #1;
    chk("idle_wb", wb_valid, 0);
    chk("idle_err", mem_error, 0);
    chk("idle_req", dmem_req, 0);
    if (data_known) chk("wb_data_hold", wb_data, exp_data);
  endtask

  initial begin
    resetn = 1'b0; valid_in = 1'b0; alu_out = '0; store_data = '0;
    mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0; dest_reg = '0;
    dmem_rdata = '0; dmem_ack = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    #1;
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_dest", wb_dest, 0);
    chk("rst_wb_rw", wb_reg_write, 0);
    chk("rst_err", mem_error, 0);
    chk("rst_stall", stall, 0);
    exp_data = '0; data_known = 1;
    @(negedge CLOCK_50);
    resetn = 1'b1;

    // directed cases
    run_instr(0, 0, 32'h0000_1234, 32'h0, 1, 5'd7, 0, 0);
    run_instr(0, 0, 32'h0000_5678, 32'h0, 0, 5'd9, 0, 0);
    idle_cycle();
    // load with ack on the third req cycle; rdata random via model, plus fixed one below
    drive(1, 0, 32'h100, 32'h0, 1, 5'd3);
    dmem_ack = 1'b0; #1;
    chk("ld_stall", stall, 1);
    @(negedge CLOCK_50); valid_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("ld_req", dmem_req, 1);
      chk("ld_addr", dmem_addr, 32'h100);
      chk("ld_we", dmem_we, 0);
      chk("ld_stall_h", stall, 1);
      dmem_ack = (k == 2); dmem_rdata = 32'hDEAD_BEEF;
      @(negedge CLOCK_50);
    end
    dmem_ack = 1'b0; #1;
    chk("ld_wb_valid", wb_valid, 1);
    chk("ld_wb_data", wb_data, 32'hDEAD_BEEF);
    chk("ld_wb_rw", wb_reg_write, 1);
    chk("ld_wb_dest", wb_dest, 3);
    chk("ld_err", mem_error, 0);
    exp_data = 32'hDEAD_BEEF; data_known = 1;
    idle_cycle();
    run_instr(0, 1, 32'h40, 32'hA5A5_A5A5, 1, 5'd4, 0, 0);
    run_instr(1, 0, 32'h102, 32'h0, 1, 5'd2, 0, 0);
    idle_cycle();
    run_instr(1, 0, 32'h200, 32'h0, 1, 5'd6, 99, 1);
    run_instr(1, 0, 32'h204, 32'h0, 1, 5'd6, int'(TO) - 1, 0);
    run_instr(1, 1, 32'h208, 32'h1111_2222, 1, 5'd8, 1, 0);
    idle_cycle();

    // reset in the middle of an access
    drive(1, 0, 32'h300, 32'h0, 1, 5'd1);
    @(negedge CLOCK_50); valid_in = 1'b0; #1;
    chk("mid_req", dmem_req, 1);
    @(negedge CLOCK_50);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_req", dmem_req, 0);
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_wb", wb_valid, 0);
    @(negedge CLOCK_50);
    resetn = 1'b1;
    exp_data = '0; data_known = 1;
    idle_cycle();
    idle_cycle();
    run_instr(0, 0, 32'hCAFE_0001, 32'h0, 1, 5'd12, 0, 0);
    idle_cycle();

    // random instruction stream
    for (int n = 0; n < 300; n++) begin
      int kind;
      logic [31:0] a;
      kind = $urandom_range(0, 3);
      a = $urandom();
      case (kind)
        0: run_instr(0, 0, a, $urandom(), 1'($urandom()), DW'($urandom()), 0, 0);
        1, 2: run_instr(1'($urandom()) | (kind == 1), 1'($urandom()), a & 32'hFFFF_FFFC,
                        $urandom(), 1'($urandom()), DW'($urandom()),
                        $urandom_range(0, TO + 1), 1'($urandom()));
        default: run_instr(1'($urandom()) | (kind == 3), 1'($urandom()),
                           a | 32'(1 + $urandom_range(0, 2)), $urandom(),
                           1'($urandom()), DW'($urandom()), 0, 0);
      endcase
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
